// File: rtl/fetch_seq.sv
// Fetch sequencer: issues word-aligned icache requests into a small prefetch buffer and
// handles redirects. Define FETCH_SEQ_C_EXT_EN to accept halfword-aligned redirect targets.
module fetch_seq #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     BUF_DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            icache_req_o,
  output logic [XLEN-1:0] icache_addr_o,
  input  logic            icache_ack_i,
  input  logic [31:0]     icache_instr_i,
  output logic            buf_push_o,
  output logic [31:0]     buf_wdata_o,
  output logic            buf_flush_o,
  input  logic            buf_pop_i,
  output logic            start_half_o,
  output logic            misalign_o,
  output logic            busy_o
);

  localparam int unsigned    CW    = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0]  DEPTH = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StDiscard} state_e;

  state_e          state_q;
  logic [XLEN-3:0] fetch_addr_q;
  logic [XLEN-3:0] pend_addr_q;
  logic [CW-1:0]   count_q;
  logic            start_half_q;
  logic            lock_q;
  logic            misalign_q;

  logic            pc_bad;
  logic [XLEN-3:0] target_w;
  logic            pop_ok;
  logic [CW-1:0]   count_acked;
  logic            unused_pc_bit0;

`ifdef FETCH_SEQ_C_EXT_EN
  assign pc_bad       = 1'b0;
  assign start_half_o = start_half_q;
`else
  logic unused_start_half;
  assign pc_bad            = redirect_pc_i[1];
  assign start_half_o      = 1'b0;
  assign unused_start_half = start_half_q;
`endif

  assign unused_pc_bit0 = redirect_pc_i[0];
  assign target_w       = redirect_pc_i[XLEN-1:2];
  assign pop_ok         = buf_pop_i && (count_q != '0);
  assign count_acked    = pop_ok ? count_q : count_q + CW'(1);

  assign icache_req_o  = (state_q == StFetch) || (state_q == StDiscard);
  assign busy_o        = icache_req_o;
  assign icache_addr_o = {fetch_addr_q, 2'b00};
  assign buf_push_o    = (state_q == StFetch) && icache_ack_i && !redirect_i;
  assign buf_wdata_o   = icache_instr_i;
  assign buf_flush_o   = redirect_i;
  assign misalign_o    = misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      fetch_addr_q <= RESET_PC[XLEN-1:2];
      pend_addr_q  <= RESET_PC[XLEN-1:2];
      count_q      <= '0;
      start_half_q <= RESET_PC[1];
      lock_q       <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      misalign_q <= redirect_i && pc_bad;
      if (redirect_i) begin
        count_q      <= '0;
        start_half_q <= redirect_pc_i[1];
        lock_q       <= pc_bad;
        if (state_q == StFetch && !icache_ack_i) begin
          // Keep the unacked request on the bus; its response will be dropped.
          state_q     <= StDiscard;
          pend_addr_q <= target_w;
        end else if (state_q == StDiscard && !icache_ack_i) begin
          pend_addr_q <= target_w;
        end else begin
          fetch_addr_q <= target_w;
          state_q      <= (fetch_en_i && !pc_bad) ? StFetch : StIdle;
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            if (pop_ok) count_q <= count_q - CW'(1);
            if (fetch_en_i && (count_q < DEPTH) && !lock_q) state_q <= StFetch;
          end
          StFetch: begin
            if (icache_ack_i) begin
              count_q      <= count_acked;
              fetch_addr_q <= fetch_addr_q + 1'b1;
              state_q      <= (fetch_en_i && (count_acked < DEPTH)) ? StFetch : StIdle;
            end else if (pop_ok) begin
              count_q <= count_q - CW'(1);
            end
          end
          StDiscard: begin
            if (pop_ok) count_q <= count_q - CW'(1);
            if (icache_ack_i) begin
              fetch_addr_q <= pend_addr_q;
              state_q      <= (fetch_en_i && !lock_q) ? StFetch : StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed walk through the main scenarios, then random traffic,
// all checked against a transaction-level model (outstanding request + buffer queue).
module tb_fetch_seq;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en_i, redirect_i, icache_ack_i, buf_pop_i;
  logic [31:0] redirect_pc_i, icache_instr_i;
  logic        icache_req_o, buf_push_o, buf_flush_o, start_half_o, misalign_o, busy_o;
  logic [31:0] icache_addr_o, buf_wdata_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic        m_pend, m_stale, m_lock, m_mis, m_half;
  logic [31:0] m_req, m_pc;
  logic [31:0] m_buf[$];

  fetch_seq dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en_i     (fetch_en_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .icache_req_o   (icache_req_o),
    .icache_addr_o  (icache_addr_o),
    .icache_ack_i   (icache_ack_i),
    .icache_instr_i (icache_instr_i),
    .buf_push_o     (buf_push_o),
    .buf_wdata_o    (buf_wdata_o),
    .buf_flush_o    (buf_flush_o),
    .buf_pop_i      (buf_pop_i),
    .start_half_o   (start_half_o),
    .misalign_o     (misalign_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend  = 1'b0;
    m_stale = 1'b0;
    m_lock  = 1'b0;
    m_mis   = 1'b0;
    m_half  = RESET_PC[1];
    m_pc    = {RESET_PC[31:2], 2'b00};
    m_req   = m_pc;
    m_buf.delete();
  endtask

  function automatic logic target_bad(input logic [31:0] pc);
`ifdef FETCH_SEQ_C_EXT_EN
    return 1'b0;
`else
    return pc[1];
`endif
  endfunction

  task automatic issue();
    m_pend  = 1'b1;
    m_stale = 1'b0;
    m_req   = m_pc;
  endtask

  task automatic check_outputs();
    logic exp_half;
`ifdef FETCH_SEQ_C_EXT_EN
    exp_half = m_half;
`else
    exp_half = 1'b0;
`endif
    chk("req", icache_req_o, m_pend);
    chk("addr", icache_addr_o, m_pend ? m_req : m_pc);
    chk("push", buf_push_o, m_pend && !m_stale && icache_ack_i && !redirect_i);
    chk("wdata", buf_wdata_o, icache_instr_i);
    chk("flush", buf_flush_o, redirect_i);
    chk("busy", busy_o, m_pend);
    chk("misalign", misalign_o, m_mis);
    chk("start_half", start_half_o, exp_half);
  endtask

  task automatic model_step();
    int   occ;
    logic bad;
    occ   = m_buf.size();
    bad   = target_bad(redirect_pc_i);
    m_mis = redirect_i && bad;
    if (redirect_i) begin
      m_buf.delete();
      m_half = redirect_pc_i[1];
      m_lock = bad;
      m_pc   = {redirect_pc_i[31:2], 2'b00};
      if (m_pend && !icache_ack_i) begin
        m_stale = 1'b1;
      end else begin
        m_pend  = 1'b0;
        m_stale = 1'b0;
        if (fetch_en_i && !m_lock) issue();
      end
    end else begin
      if (buf_pop_i && occ > 0) void'(m_buf.pop_front());
      if (m_pend && icache_ack_i) begin
        if (m_stale) begin
          m_pend  = 1'b0;
          m_stale = 1'b0;
          if (fetch_en_i && !m_lock) issue();
        end else begin
          m_buf.push_back(icache_instr_i);
          m_pc   = m_req + 32'd4;
          m_pend = 1'b0;
          if (fetch_en_i && m_buf.size() < DEPTH) issue();
        end
      end else if (!m_pend) begin
        if (fetch_en_i && occ < DEPTH && !m_lock) issue();
      end
    end
  endtask

  // Drive one cycle of inputs, check mid-cycle, then advance the model on the edge.
  task automatic cycle(input logic en, input logic rd, input logic [31:0] rpc,
                       input logic ack, input logic [31:0] ins, input logic pop);
    fetch_en_i     = en;
    redirect_i     = rd;
    redirect_pc_i  = rpc;
    icache_ack_i   = ack;
    icache_instr_i = ins;
    buf_pop_i      = pop;
    #4;
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    logic        en, rd, ack, pop;
    logic [31:0] rpc;
    rst_n = 1'b0;
    fetch_en_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    icache_ack_i = 1'b0; icache_instr_i = '0; buf_pop_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", icache_req_o, 1'b0);
    chk("rst_addr", icache_addr_o, {RESET_PC[31:2], 2'b00});
    chk("rst_busy", busy_o, 1'b0);
    check_outputs();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill the buffer with acks every cycle, no pops
    cycle(1, 0, 0, 0, 0, 0);
    chk("first_req", icache_req_o, 1'b1);
    chk("first_addr", icache_addr_o, 32'h0);
    cycle(1, 0, 0, 1, 32'hA000_0000, 0);
    chk("second_addr", icache_addr_o, 32'h4);
    cycle(1, 0, 0, 1, 32'hA000_0004, 0);
    chk("full_stall", icache_req_o, 1'b0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("full_stall2", icache_req_o, 1'b0);
    cycle(1, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0);
    chk("refill_addr", icache_addr_o, 32'h8);
    chk("refill_req", icache_req_o, 1'b1);

    // Redirect while the 0x8 request is unacked
    cycle(1, 1, 32'h0000_1002, 0, 0, 0);
    chk("discard_req", icache_req_o, 1'b1);
    chk("discard_addr", icache_addr_o, 32'h8);
`ifndef FETCH_SEQ_C_EXT_EN
    chk("misalign_pulse", misalign_o, 1'b1);
`endif
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 32'hDEAD_BEEF, 0);
`ifdef FETCH_SEQ_C_EXT_EN
    chk("after_discard_addr", icache_addr_o, 32'h1000);
    chk("after_discard_half", start_half_o, 1'b1);
`else
    chk("locked_idle", icache_req_o, 1'b0);
`endif
    cycle(1, 0, 0, 0, 0, 0);

    // Legal redirect, then redirect coincident with ack
    cycle(1, 1, 32'h0000_2000, 1, 32'h1111_1111, 0);
    chk("legal_addr", icache_addr_o, 32'h2000);
    chk("legal_req", icache_req_o, 1'b1);
    cycle(1, 1, 32'h0000_3000, 1, 32'h2222_2222, 0);
    chk("coinc_addr", icache_addr_o, 32'h3000);

    // Drop fetch enable mid-request
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h3333_3333, 0);
    chk("halt_req", icache_req_o, 1'b0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("resume_addr", icache_addr_o, 32'h3004);

    // Address wrap
    cycle(1, 1, 32'hFFFF_FFFC, 1, 32'h4444_4444, 0);
    chk("wrap_top", icache_addr_o, 32'hFFFF_FFFC);
    cycle(1, 0, 0, 1, 32'h5555_5555, 0);
    chk("wrap_zero", icache_addr_o, 32'h0);

    // Halfword target: legal only with compressed support
    cycle(1, 1, 32'h0000_2002, 1, 32'h6666_6666, 0);
`ifdef FETCH_SEQ_C_EXT_EN
    chk("half_addr", icache_addr_o, 32'h2000);
`else
    chk("mis_pulse2", misalign_o, 1'b1);
    chk("mis_noreq", icache_req_o, 1'b0);
`endif
    cycle(1, 0, 0, 0, 0, 0);
    chk("mis_clear", misalign_o, 1'b0);
    cycle(1, 1, 32'h0000_2000, 0, 0, 0);
    chk("relock_addr", icache_addr_o, 32'h2000);

    // Asynchronous reset mid-request, then a stale ack in idle
    cycle(1, 0, 0, 0, 0, 0);
    fetch_en_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", busy_o, 1'b0);
    chk("async_req", icache_req_o, 1'b0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(0, 0, 0, 1, 32'h7777_7777, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom_range(9) < 8);
      rd  = ($urandom_range(19) == 0);
      rpc = $urandom;
      if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      ack = m_pend ? ($urandom_range(9) < 6) : ($urandom_range(19) == 0);
      pop = (m_buf.size() > 0) && ($urandom_range(1) == 1);
      cycle(en, rd, rpc, ack, $urandom, pop);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
